jk_excitation_driver: RTL and testbench

//   Drives the J/K inputs of an external bank of WIDTH JK flip-flops so the bank moves
//   to a requested target state. It implements the JK excitation table (current Q,

---
 rtl/jk_excitation_driver_if.sv | 25 ++
 rtl/jk_excitation_driver.sv | 119 +++++++++++
 tb/tb_jk_excitation_driver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jk_excitation_driver_if.sv
// Target request, JK bank feedback/excitation and status bundle for jk_excitation_driver.
// The master is the sequencer/bank side and the slave is the driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             done;
  logic             err;
  logic             err_clr;

  modport master (
    output tgt_valid, tgt_data, q_fb, err_clr,
    input  tgt_ready, j_out, k_out, done, err
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb, err_clr,
    output tgt_ready, j_out, k_out, done, err
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives a JK bank to a target and verifies it via q_fb: done 3 cycles after accept (1 if already equal).
// tgt_ready is held low while busy or in ERROR; JK_TOGGLE_EN selects toggle (J=K=q^t) excitation.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  jk_excitation_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_q, tgt_nxt;
  logic [WIDTH-1:0] j_q, j_nxt, k_q, k_nxt;
  logic [WIDTH-1:0] exc_tgt, exc_j, exc_k;
  logic [3:0]       retry_q, retry_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             accept;

  assign bus.tgt_ready = (state == IDLE);
  assign accept        = bus.tgt_valid && bus.tgt_ready;

  // In IDLE the excitation targets the incoming request, afterwards the latched one.
  assign exc_tgt = (state == IDLE) ? bus.tgt_data : tgt_q;

`ifdef JK_TOGGLE_EN
  assign exc_j = bus.q_fb ^ exc_tgt;
  assign exc_k = bus.q_fb ^ exc_tgt;
`else
  assign exc_j = ~bus.q_fb & exc_tgt;
  assign exc_k = bus.q_fb & ~exc_tgt;
`endif

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt_q;
    retry_nxt = retry_q;
    j_nxt     = '0;
    k_nxt     = '0;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          tgt_nxt   = bus.tgt_data;
          retry_nxt = '0;
          if (bus.q_fb == bus.tgt_data) begin
            done_nxt = 1'b1;
          end else begin
            j_nxt     = exc_j;
            k_nxt     = exc_k;
            state_nxt = DRIVE;
          end
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (bus.q_fb == tgt_q) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (retry_q < RETRY_LIM) begin
          retry_nxt = retry_q + 4'd1;
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = DRIVE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        if (bus.err_clr) begin
          err_nxt   = 1'b0;
          retry_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tgt_q   <= tgt_nxt;
      j_q     <= j_nxt;
      k_q     <= k_nxt;
      retry_q <= retry_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.j_out = j_q;
  assign bus.k_out = k_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: JK bank model with stuck-bit injection and a transaction-level reference.
// Honours JK_TOGGLE_EN the same way the design does.
module tb_jk_excitation_driver;

  localparam int W  = 4;
  localparam int MR = 2;

  logic         CLK;
  logic         RST_n;
  logic [W-1:0] bank;
  logic         load_en;
  logic [W-1:0] load_val;
  logic [W-1:0] stuck_lo;
  logic [W-1:0] stuck_hi;
  int           checks;
  int           errors;

  jk_excitation_driver_if #(.WIDTH(W)) bus ();

  jk_excitation_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Excitation table, one bit: returns {J,K} for current q and desired t.
  function automatic logic [1:0] exc_bit(input logic q, input logic t);
`ifdef JK_TOGGLE_EN
    return (q != t) ? 2'b11 : 2'b00;
`else
    case ({q, t})
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
`endif
  endfunction

  // JK flip-flop characteristic: hold, reset, set, toggle.
  function automatic logic [W-1:0] bank_step(input logic [W-1:0] q, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)       bank <= '0;
    else if (load_en) bank <= load_val;
    else              bank <= bank_step(bank, bus.j_out, bus.k_out);
  end

  assign bus.q_fb = (bank & ~stuck_lo) | stuck_hi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: attempts until the visible bank equals the target.
  task automatic model_txn(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                           input logic [W-1:0] lo, input logic [W-1:0] hi,
                           output int lat, output int drives, output logic err_exp,
                           output logic [W-1:0] j1, output logic [W-1:0] k1,
                           output logic [W-1:0] q_final);
    logic [W-1:0] b, q, j, k;
    logic [1:0]   jk;
    b = q0; q = (b & ~lo) | hi;
    j1 = '0; k1 = '0; drives = 0; err_exp = 1'b0; lat = 1;
    if (q != tgt) begin
      err_exp = 1'b1;
      lat = 2 * MR + 3;
      for (int a = 0; a <= MR; a++) begin
        for (int i = 0; i < W; i++) begin
          jk = exc_bit(q[i], tgt[i]);
          j[i] = jk[1];
          k[i] = jk[0];
        end
        if (a == 0) begin j1 = j; k1 = k; end
        b = bank_step(b, j, k);
        q = (b & ~lo) | hi;
        drives++;
        if (q == tgt) begin
          err_exp = 1'b0;
          lat = 3 + 2 * a;
          break;
        end
      end
    end
    q_final = q;
  endtask

  task automatic run_txn(input logic [W-1:0] q0, input logic [W-1:0] tgt,
                         input logic [W-1:0] lo, input logic [W-1:0] hi);
    int           exp_lat, exp_drv, got_lat, got_drv;
    logic         exp_err, overlap;
    logic [W-1:0] j1, k1, qf;
    model_txn(q0, tgt, lo, hi, exp_lat, exp_drv, exp_err, j1, k1, qf);
    stuck_lo = lo;
    stuck_hi = hi;
    @(negedge CLK);
    load_val = q0;
    load_en  = 1'b1;
    @(negedge CLK);
    load_en       = 1'b0;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = tgt;
    check("ready_before_accept", 32'(bus.tgt_ready), 32'd1);
    got_lat = 0;
    got_drv = 0;
    overlap = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge CLK);
      if ((bus.j_out | bus.k_out) != '0) got_drv++;
      if ((bus.j_out & bus.k_out) != '0) overlap = 1'b1;
      if (n == 1) begin
        check("j_first", 32'(bus.j_out), 32'(j1));
        check("k_first", 32'(bus.k_out), 32'(k1));
      end
      if (bus.done || bus.err) begin
        got_lat = n;
        break;
      end
      // Requests and err_clr arriving while busy must be ignored.
      bus.tgt_data  = W'($urandom);
      bus.tgt_valid = (n == 1);
      bus.err_clr   = (n == 2);
    end
    bus.tgt_valid = 1'b0;
    bus.err_clr   = 1'b0;
    check("latency", 32'(got_lat), 32'(exp_lat));
    check("drive_pulses", 32'(got_drv), 32'(exp_drv));
    check("err", 32'(bus.err), 32'(exp_err));
    check("q_final", 32'(bus.q_fb), 32'(qf));
`ifndef JK_TOGGLE_EN
    check("no_j_k_both", 32'(overlap), 32'd0);
`endif
    if (!exp_err) begin
      check("ready_at_done", 32'(bus.tgt_ready), 32'd1);
      @(negedge CLK);
      check("done_one_cycle", 32'(bus.done), 32'd0);
    end else begin
      check("ready_in_error", 32'(bus.tgt_ready), 32'd0);
      repeat (3) @(negedge CLK);
      check("err_sticky", 32'(bus.err), 32'd1);
      check("jk_zero_in_error", 32'(bus.j_out | bus.k_out), 32'd0);
      bus.err_clr = 1'b1;
      @(negedge CLK);
      bus.err_clr = 1'b0;
      check("err_cleared", 32'(bus.err), 32'd0);
      check("ready_after_clr", 32'(bus.tgt_ready), 32'd1);
    end
  endtask

  initial begin
    logic [W-1:0] rq, rt, rl;
    checks = 0;
    errors = 0;
    RST_n = 1'b0;
    load_en = 1'b0;
    load_val = '0;
    stuck_lo = '0;
    stuck_hi = '0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data = '0;
    bus.err_clr = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_j", 32'(bus.j_out), 32'd0);
    check("rst_k", 32'(bus.k_out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    RST_n = 1'b1;
    @(negedge CLK);
    check("ready_after_rst", 32'(bus.tgt_ready), 32'd1);

    // Asynchronous reset in the middle of a DRIVE cycle drops the request.
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1010;
    @(negedge CLK);
    bus.tgt_valid = 1'b0;
    check("drive_before_rst", 32'(bus.j_out), 32'hA);
    #2 RST_n = 1'b0;
    #1;
    check("async_rst_j", 32'(bus.j_out), 32'd0);
    check("async_rst_k", 32'(bus.k_out), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    check("async_rst_err", 32'(bus.err), 32'd0);
    check("async_rst_idle", 32'(bus.tgt_ready), 32'd1);
    @(negedge CLK);
    RST_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      check("no_replay", 32'({bus.done, bus.j_out, bus.k_out}), 32'd0);
    end

    run_txn(4'b0000, 4'b1010, 4'b0000, 4'b0000);
    run_txn(4'b1111, 4'b0110, 4'b0000, 4'b0000);
    run_txn(4'b0101, 4'b0101, 4'b0000, 4'b0000);
    run_txn(4'b0000, 4'b0001, 4'b0001, 4'b0000);
    run_txn(4'b0011, 4'b0101, 4'b0000, 4'b0000);

    for (int it = 0; it < 40; it++) begin
      rq = W'($urandom);
      rt = W'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      run_txn(rq, rt, rl, 4'b0000);
    end
    run_txn(4'b0000, 4'b1111, 4'b0000, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
